// File: rtl/alu_seq_pkg.sv
// Shared opcode, flag-index and FSM state definitions for the sequential ALU.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_SLA = 3'b000,
        OP_SRA = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_MUL = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_NOT = 3'b111
    } op_e;

    localparam int FLG_Z = 0;
    localparam int FLG_V = 1;
    localparam int FLG_N = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MUL  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative radix-2 sign-magnitude multiplier: one bit of |b| per cycle into a
// 2*WIDTH accumulator; done is high during the cycle whose edge completes the product.
module alu_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] full;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     hi;
    logic               neg_q;
    logic [CW-1:0]      cnt_q;

    // The most-negative operand's magnitude still fits as an unsigned WIDTH value.
    assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign busy  = (cnt_q != '0);
    assign done  = (cnt_q == CW'(1));
    assign full  = neg_q ? (~acc_d + 1'b1) : acc_d;
    assign prod  = full[WIDTH-1:0];
    assign hi    = full[2*WIDTH-1:WIDTH-1];
    assign ovf   = !((hi == '0) || (hi == '1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            cnt_q    <= CW'(WIDTH);
        end else if (busy) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU, one operation in flight. Define ALU_SEQ_MUL_EN to
// build the iterative multiplier; otherwise opcode 100 returns c=0, d=3'b011.
//
// state | meaning
// IDLE  | waiting for an operation
// EXEC  | single-cycle op computing from captured operands
// MUL   | iterative multiply in progress
// DONE  | result held until out_ready
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [2:0]       d
);
    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [2:0]       d_q;
    logic             accept;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sla_top;
    logic [WIDTH-1:0] ex_c;
    logic             ex_v;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign c         = c_q;
    assign d         = d_q;

`ifdef ALU_SEQ_MUL_EN
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic             mul_ovf;
    logic [WIDTH-1:0] mul_p;

    assign mul_start = accept && (op_e'(opcode) == OP_MUL);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_p),
        .ovf   (mul_ovf)
    );
`endif

    always_comb begin
        shamt = b_q[SHW-1:0];
        // Low shamt+1 bits are a[MSB:MSB-shamt]; all equal iff this is all 0s or all 1s.
        sla_top = $signed(a_q) >>> (SHW'(WIDTH - 1) - shamt);
        ex_c = '0;
        ex_v = 1'b0;
        case (op_q)
            OP_SLA: begin
                ex_c = a_q << shamt;
                ex_v = !((sla_top == '0) || (sla_top == '1));
            end
            OP_SRA: ex_c = $signed(a_q) >>> shamt;
            OP_ADD: begin
                ex_c = a_q + b_q;
                ex_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ex_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                ex_c = a_q - b_q;
                ex_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (ex_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: ex_c = a_q & b_q;
            OP_OR:  ex_c = a_q | b_q;
            OP_NOT: ex_c = ~a_q;
            default: begin
                ex_c = '0;
                ex_v = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_SLA;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        a_q  <= a;
                        b_q  <= b;
                        op_q <= op_e'(opcode);
`ifdef ALU_SEQ_MUL_EN
                        state_q <= (op_e'(opcode) == OP_MUL) ? MUL : EXEC;
`else
                        state_q <= EXEC;
`endif
                    end else if ((state_q == DONE) && out_ready) begin
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    c_q     <= ex_c;
                    d_q     <= {ex_c[WIDTH-1], ex_v, (ex_c == '0)};
                    state_q <= DONE;
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    if (mul_done) begin
                        c_q     <= mul_p;
                        d_q     <= {mul_p[WIDTH-1], mul_ovf, (mul_p == '0)};
                        state_q <= DONE;
                    end else if (!mul_busy) begin
                        state_q <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized + directed bench for alu_seq with a behavioural reference model and scoreboard.
module tb_alu_seq;
    localparam int W  = 32;
    localparam int SH = $clog2(W);
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;
    logic [2:0]   d;

    logic rr_en = 1'b0;
    logic rr_bit = 1'b0;
    logic or_force = 1'b1;
    assign out_ready = rr_en ? rr_bit : or_force;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] c;
        logic [2:0]   d;
        int           acc;
        int           lat;
    } exp_t;
    exp_t q[$];
    bit head_seen = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        rr_bit = 1'($urandom_range(0, 1));
    end

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .d         (d)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    // Returns {c, d} from the arithmetic meaning of each operation.
    function automatic logic [W+2:0] model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint       sx = longint'($signed(x));
        longint       sy = longint'($signed(y));
        longint       maxs = (longint'(1) <<< (W - 1)) - 1;
        longint       mins = -(longint'(1) <<< (W - 1));
        longint       r;
        logic [W-1:0] rc;
        logic         v;
        int           sh = int'(y[SH-1:0]);
        rc = '0;
        v = 1'b0;
        case (op)
            3'd0: begin
                rc = x << sh;
                v = (($signed(rc) >>> sh) != $signed(x));
            end
            3'd1: rc = $signed(x) >>> sh;
            3'd2: begin r = sx + sy; rc = r[W-1:0]; v = (r > maxs) || (r < mins); end
            3'd3: begin r = sx - sy; rc = r[W-1:0]; v = (r > maxs) || (r < mins); end
            3'd4: begin
                if (MUL_EN) begin
                    r = sx * sy;
                    rc = r[W-1:0];
                    v = (r != longint'($signed(rc)));
                end else begin
                    rc = '0;
                    v = 1'b1;
                end
            end
            3'd5: rc = x & y;
            3'd6: rc = x | y;
            default: rc = ~x;
        endcase
        return {rc, rc[W-1], v, (rc == '0)};
    endfunction

    function automatic int model_lat(input logic [2:0] op);
        return (MUL_EN && op == 3'd4) ? W + 1 : 2;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [W+2:0] m;
        if (rst) begin
            q.delete();
            head_seen = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("mon_out_valid_without_op", out_valid, 0);
                end else begin
                    chk("mon_c", c, q[0].c);
                    chk("mon_d", d, q[0].d);
                    if (!head_seen) begin
                        chk("mon_latency", cyc - q[0].acc + 1, q[0].lat);
                        head_seen = 1'b1;
                    end
                    if (out_ready) begin
                        q.delete(0);
                        head_seen = 1'b0;
                    end
                end
            end else if (q.size() != 0) begin
                chk("mon_busy_in_ready", in_ready, 0);
            end else begin
                chk("mon_idle_in_ready", in_ready, 1);
            end
            if (in_valid && in_ready) begin
                m = model(opcode, a, b);
                e.c = m[W+2:3];
                e.d = m[2:0];
                e.acc = cyc + 1;
                e.lat = model_lat(opcode);
                q.push_back(e);
            end
        end
    end

    // Start at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        in_valid = 1'b1;
        opcode = op;
        a = x;
        b = y;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 500);
        if (!in_ready) chk("issue_timeout_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string nm, input logic [W-1:0] ec, input logic [2:0] ed, input int elat);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 200);
        chk({nm, "_latency"}, k, elat);
        chk({nm, "_c"}, c, ec);
        chk({nm, "_d"}, d, ed);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return '1;
            4: return W'($urandom_range(0, 40));
            5: return -W'($urandom_range(1, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        opcode = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_c", c, 0);
        chk("reset_d", d, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        chk("model_add_ovf", model(3'd2, 32'h7FFF_FFFF, 32'd1), {32'h8000_0000, 3'b110});
        chk("model_sla", model(3'd0, 32'h4000_0000, 32'd1), {32'h8000_0000, 3'b110});
        chk("model_sra", model(3'd1, 32'h8000_0000, 32'd31), {32'hFFFF_FFFF, 3'b100});
        chk("model_mul", model(3'd4, -32'sd3, 32'd7), MUL_EN ? {32'hFFFF_FFEB, 3'b100} : {32'h0, 3'b011});

        issue(3'd2, 32'h7FFF_FFFF, 32'd1);
        expect_result("add_ovf", 32'h8000_0000, 3'b110, 2);
        issue(3'd4, -32'sd3, 32'd7);
        expect_result("mul_neg", MUL_EN ? 32'hFFFF_FFEB : 32'h0, MUL_EN ? 3'b100 : 3'b011, MUL_EN ? 33 : 2);
        issue(3'd4, 32'h0001_0000, 32'h0001_0000);
        expect_result("mul_ovf", 32'h0, 3'b011, MUL_EN ? 33 : 2);
        issue(3'd0, 32'h4000_0000, 32'd1);
        expect_result("sla_ovf", 32'h8000_0000, 3'b110, 2);
        issue(3'd1, 32'h8000_0000, 32'd31);
        expect_result("sra_31", 32'hFFFF_FFFF, 3'b100, 2);
        issue(3'd3, 32'h8000_0000, 32'd1);
        expect_result("sub_ovf", 32'h7FFF_FFFF, 3'b010, 2);
        issue(3'd7, 32'h0, 32'h1234);
        expect_result("not_zero", 32'hFFFF_FFFF, 3'b100, 2);

        or_force = 1'b0;
        issue(3'd5, 32'hF0, 32'h0F);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 200);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_c", c, 0);
            chk("bp_hold_d", d, 3'b001);
            chk("bp_hold_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        opcode = 3'd2;
        a = 32'd2;
        b = 32'd3;
        or_force = 1'b1;
        @(negedge clk);
        chk("bp_same_edge_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect_result("bp_next_add", 32'd5, 3'b000, 2);

        issue(3'd4, 32'h0001_2345, 32'h0000_0777);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_c", c, 0);
        chk("rst_mid_d", d, 0);
        @(posedge clk);
        #1;
        issue(3'd2, 32'd2, 32'd2);
        expect_result("post_rst_add", 32'd4, 3'b000, 2);

        rr_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
        rr_en = 1'b0;
        or_force = 1'b1;
        k = 0;
        while (q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        chk("drain_queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's combinational 8-op ALU. It keeps the same opcode map and adds:
- a WIDTH-generic datapath
- variable shift amounts
- a full signed WIDTH×WIDTH iterative multiplier with a real overflow flag
- valid/ready flow control on both input and output

It sits between the operand-issue stage and the writeback register, and holds one operation in flight at a time.

## Interface
- WIDTH, 32: operand/result width; ≥ 4, power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived, do not override).
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A, signed.
- b  input  WIDTH  operand B, signed; b[SHW-1:0] is the shift amount for shifts.
- opcode  input  3  operation select: 000 sla, 001 sra, 010 add, 011 sub, 100 mul, 101 and, 110 or, 111 not.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes the result this cycle.
- c  output  WIDTH  result, signed.
- d  output  3  flags: d[0] zero, d[1] overflow, d[2] negative.

## Operation
- **Accept:** the block accepts an operation on an edge where in_valid && in_ready. a, b and opcode are captured; they need not be held afterwards.
- **States:**
  - IDLE → EXEC on accept of any opcode except mul.
  - IDLE → MUL on accept of mul.
  - EXEC → DONE after 1 cycle.
  - MUL → DONE after WIDTH iterations.
  - DONE → IDLE when out_ready.
  - DONE → EXEC/MUL directly when out_ready is high and a new operation is accepted on the same edge.
- **Handshake signals:** in_ready = (state==IDLE) || (state==DONE && out_ready). out_valid = (state==DONE).
- **Holding:** c and d are stable while out_valid && !out_ready.
- **sla:** c = a << shamt. Overflow = 1 unless bits a[WIDTH-1 : WIDTH-1-shamt] are all equal. shamt=0 → overflow 0.
- **sra:** c = a >>> shamt, arithmetic. Overflow 0.
- **add/sub:** modulo 2^WIDTH. Overflow is two's-complement signed overflow.
- **mul:**
  - Radix-2 sign-magnitude: |a|·|b| by shift-add, one bit of |b| per cycle, into a 2·WIDTH accumulator. Negate at the end if a[WIDTH-1]^b[WIDTH-1].
  - c = low WIDTH bits.
  - Overflow = 1 when the upper WIDTH bits are not the sign-extension of c[WIDTH-1].
  - The most-negative operand is handled by the 2·WIDTH accumulator.
- **and/or/not:** bitwise; not ignores b. Overflow 0.
- **Flags for all ops:** zero = (c==0); negative = c[WIDTH-1]. Flags never drive z or x.

## Timing
- **Reset values:** state IDLE, in_ready 1, out_valid 0, c 0, d 3'b000. The multiplier accumulator and counter are cleared.
- **Reset mid-operation:** rst mid-MUL or in DONE aborts the operation. The result is discarded and out_valid is 0 the next cycle.
- **Latency:**
  - Non-mul: out_valid rises 2 edges after the accept edge (EXEC, then DONE).
  - mul: out_valid rises WIDTH+1 edges after the accept edge.
- **Throughput:** back-to-back is legal. With out_ready held high, a new operation is accepted on the same edge the previous result is consumed.
- **Busy:** in_ready is 0 during EXEC and MUL. in_valid is ignored then.

## Configuration
- **ALU_SEQ_MUL_EN defined:** the iterative multiplier, the MUL state and the 2·WIDTH accumulator are built.
- **ALU_SEQ_MUL_EN undefined:**
  - opcode 100 is handled as a non-mul op with EXEC latency.
  - c=0, d=3'b011 (zero and overflow set, marking "unsupported").
  - No multiplier hardware is instantiated.

## Structure
- **Package alu_seq_pkg:** opcode enum (OP_SLA … OP_NOT), flag index constants (FLG_Z=0, FLG_V=1, FLG_N=2), state enum (IDLE, EXEC, MUL, DONE).
- **Sub-module alu_seq_mul:**
  - Iterative signed multiplier, WIDTH-parametrised.
  - Handshake: start/busy/done.
  - Outputs: product low half and overflow.
  - Instantiated only under ALU_SEQ_MUL_EN.
- **Top:** the top holds the FSM, the single-cycle ops and the output registers.

## Test plan
- **Add overflow:** add a=0x7FFFFFFF, b=1 → c=0x80000000, d=3'b110, out_valid 2 edges after accept.
- **Signed mul:** mul a=-3, b=7 → c=0xFFFFFFEB, d=3'b100, out_valid exactly 33 edges after accept. mul a=0x00010000, b=0x00010000 → c=0, d=3'b011.
- **Shifts:** sla a=0x40000000, b=1 → c=0x80000000, d=3'b110. sra a=0x80000000, b=31 → c=0xFFFFFFFF, d=3'b100.
- **Backpressure:** hold out_ready=0 for 5 cycles after an and (a=0xF0, b=0x0F → c=0, d=3'b001). c/d are stable, in_ready stays 0. Raising out_ready with in_valid high accepts the next op on that same edge.
- **Reset mid-mul:** rst pulsed 10 cycles into a mul → next cycle out_valid=0, in_ready=1, c=0, d=0. A following add 2+2 returns 4, d=3'b000.
- **Macro off:** with ALU_SEQ_MUL_EN undefined, mul 5×5 → c=0, d=3'b011, 2-edge latency.
